spi_master_ctrl: RTL and testbench

SPI master that drives the SPI-RAM slave's MOSI/SS_n pins and captures MISO. It converts single-word host commands into 10-bit SPI frames: write address, write data, read address and read data. For read-data frames it shifts the returned byte back in and presents it to the host. It sits between the host/testbench sequencer and the slave's MOSI, SS_n and MISO pins, on the same clk.

---
 rtl/spi_master_ctrl.sv | 193 +++++++++++++++++++
 tb/tb_spi_master_ctrl.sv | 475 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// spi_master_ctrl
//
// SPI master for the SPI-RAM slave. It turns one host command into one 10-bit
// frame {cmd_type, cmd_data}, sent MSB first on MOSI with SS_n held low for
// the whole frame. For read-data frames (cmd_type == 2'b11) it keeps SS_n low,
// waits RD_LATENCY cycles, then shifts MEM_WIDTH bits in from MISO and
// presents them on rd_data with a one-cycle rd_valid pulse.
//
// The pins (SS_n, MOSI, rd_valid, rd_data) are registered one stage behind
// the state register. Each edge drives the pins for the state that just
// ended. With the default parameters this gives:
//   - SS_n rises 12 edges after the accept edge for write and rd_addr frames.
//   - SS_n rises 22 edges after the accept edge for read-data frames.
//   - MOSI carries frame bit k during the cycle that begins at edge 2+k.
//   - MISO is sampled at edges 14..21.
//   - rd_valid is high during the cycle that begins at edge 22.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   rst        in   synchronous, active-high reset
//   cmd_valid  in   host command request
//   cmd_ready  out  command can be accepted (IDLE and not in reset)
//   cmd_type   in   00 wr_addr, 01 wr_data, 10 rd_addr, 11 rd_data
//   cmd_data   in   frame payload (shifted out even for rd_data)
//   SS_n       out  slave select, active low
//   MOSI       out  serial data to slave, MSB first
//   MISO       in   serial data from slave
//   rd_data    out  last byte captured from MISO
//   rd_valid   out  one-cycle pulse when rd_data updates
//   busy       out  high from acceptance until the return to IDLE
// -----------------------------------------------------------------------------
module spi_master_ctrl #(
    parameter int MEM_WIDTH  = 8,
    parameter int RD_LATENCY = 2,
    parameter int GAP_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_type,
    input  logic [MEM_WIDTH-1:0] cmd_data,
    output logic                 SS_n,
    output logic                 MOSI,
    input  logic                 MISO,
    output logic [MEM_WIDTH-1:0] rd_data,
    output logic                 rd_valid,
    output logic                 busy
);

    localparam int FW    = MEM_WIDTH + 2;
    localparam int MAX_A = (FW > RD_LATENCY) ? FW : RD_LATENCY;
    localparam int MAX_N = (MAX_A > GAP_CYCLES) ? MAX_A : GAP_CYCLES;
    localparam int CNT_W = $clog2(MAX_N + 1);

    // Terminal counts for each timed state. The counter runs 0..N-1.
    localparam logic [CNT_W-1:0] LAST_OUT  = CNT_W'(FW - 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);
    localparam logic [CNT_W-1:0] LAST_IN   = CNT_W'(MEM_WIDTH - 1);
    localparam logic [CNT_W-1:0] LAST_GAP  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_SHIFT_OUT,
        S_WAIT_MISO,
        S_SHIFT_IN,
        S_DESELECT
    } state_t;

    state_t               r_state;
    logic [CNT_W-1:0]     r_cnt;
    logic [FW-1:0]        r_frame;
    logic                 r_is_read;
    logic [MEM_WIDTH-1:0] r_shift;
    logic                 r_ss_n;
    logic                 r_mosi;
    logic                 r_rd_valid;
    logic [MEM_WIDTH-1:0] r_rd_data;
    logic                 r_busy;

    // rst gates cmd_ready directly, so a command presented on a reset edge is
    // never accepted.
    assign cmd_ready = (r_state == S_IDLE) && !rst;
    assign SS_n      = r_ss_n;
    assign MOSI      = r_mosi;
    assign rd_data   = r_rd_data;
    assign rd_valid  = r_rd_valid;
    assign busy      = r_busy;

    // NOTE: all state and pin registers use non-blocking assignments, so every
    // right-hand side below sees the values from before this edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_frame    <= '0;
            r_is_read  <= 1'b0;
            r_shift    <= '0;
            r_ss_n     <= 1'b1;
            r_mosi     <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= '0;
            r_busy     <= 1'b0;
        end else begin
            // NOTE: the pin defaults are assigned first. Each state then
            // overrides only what it drives, so rd_valid cannot stick high.
            r_ss_n     <= 1'b0;
            r_mosi     <= 1'b0;
            r_rd_valid <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    r_ss_n <= 1'b1;
                    // In IDLE outside reset, cmd_ready is high, so cmd_valid
                    // alone means acceptance.
                    if (cmd_valid) begin
                        r_frame   <= {cmd_type, cmd_data};
                        r_is_read <= (cmd_type == 2'b11);
                        r_busy    <= 1'b1;
                        r_state   <= S_SELECT;
                    end
                end

                S_SELECT: begin
                    r_cnt   <= '0;
                    r_state <= S_SHIFT_OUT;
                end

                S_SHIFT_OUT: begin
                    r_mosi  <= r_frame[FW-1];
                    r_frame <= {r_frame[FW-2:0], 1'b0};
                    if (r_cnt == LAST_OUT) begin
                        r_cnt <= '0;
                        if (!r_is_read) begin
                            r_state <= S_DESELECT;
                        end else if (RD_LATENCY == 0) begin
                            r_state <= S_SHIFT_IN;
                        end else begin
                            r_state <= S_WAIT_MISO;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_WAIT_MISO: begin
                    if (r_cnt == LAST_WAIT) begin
                        r_cnt   <= '0;
                        r_state <= S_SHIFT_IN;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_SHIFT_IN: begin
                    r_shift <= {r_shift[MEM_WIDTH-2:0], MISO};
                    if (r_cnt == LAST_IN) begin
                        r_cnt   <= '0;
                        r_state <= S_DESELECT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_DESELECT: begin
                    r_ss_n <= 1'b1;
                    // The shift register was completed on the previous edge.
                    // Publish it once, on the first gap cycle only.
                    if (r_is_read && r_cnt == '0) begin
                        r_rd_valid <= 1'b1;
                        r_rd_data  <= r_shift;
                    end
                    if (r_cnt == LAST_GAP) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    r_cnt   <= '0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// -----------------------------------------------------------------------------
// tb_spi_master_ctrl
//
// Directed bench for spi_master_ctrl at the default parameters.
//
// A small behavioural SPI-RAM slave decodes the frames:
//   - wr_addr and rd_addr load address registers.
//   - wr_data writes the memory.
//   - rd_data returns mem[rd_addr] on MISO, starting RD_LATENCY edges after
//     the last MOSI bit.
// On reset the slave memory is loaded with mem[i] = i ^ 8'hC3.
//
// Time t counts edges after the accept edge. Every sample is taken #1 after
// the edge.
// -----------------------------------------------------------------------------
module tb_spi_master_ctrl;

    localparam int MW     = 8;
    localparam int RD_LAT = 2;
    localparam int FW     = MW + 2;
    localparam int LOG_N  = 40;

    logic       clk       = 1'b0;
    logic       rst       = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_type  = 2'b00;
    logic [7:0] cmd_data  = 8'h00;
    logic       miso      = 1'b0;
    logic       cmd_ready;
    logic       ss_n;
    logic       mosi;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    spi_master_ctrl #(
        .MEM_WIDTH (MW),
        .RD_LATENCY(RD_LAT),
        .GAP_CYCLES(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_type (cmd_type),
        .cmd_data (cmd_data),
        .SS_n     (ss_n),
        .MOSI     (mosi),
        .MISO     (miso),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .busy     (busy)
    );

    // ---------------- behavioural SPI-RAM slave ----------------
    logic [7:0] slv_mem [0:255];
    logic [7:0] slv_wr_addr;
    logic [7:0] slv_rd_addr;
    logic [7:0] slv_tx;
    logic [9:0] slv_rx;
    logic       slv_rd_act;
    int         slv_cnt;

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) slv_mem[i] <= 8'(i) ^ 8'hC3;
            slv_wr_addr <= 8'h00;
            slv_rd_addr <= 8'h00;
            slv_tx      <= 8'h00;
            slv_rx      <= '0;
            slv_rd_act  <= 1'b0;
            slv_cnt     <= 0;
        end else if (ss_n) begin
            slv_cnt    <= 0;
            slv_rd_act <= 1'b0;
        end else begin
            slv_cnt <= slv_cnt + 1;
            // Count 0 is the select cycle. Counts 1..FW carry the MOSI bits.
            if (slv_cnt >= 1 && slv_cnt < FW) begin
                slv_rx <= {slv_rx[8:0], mosi};
            end else if (slv_cnt == FW) begin
                case (slv_rx[8:7])
                    2'b00: slv_wr_addr <= {slv_rx[6:0], mosi};
                    2'b01: slv_mem[slv_wr_addr] <= {slv_rx[6:0], mosi};
                    2'b10: slv_rd_addr <= {slv_rx[6:0], mosi};
                    default: begin
                        slv_tx     <= slv_mem[slv_rd_addr];
                        slv_rd_act <= 1'b1;
                    end
                endcase
            end
        end
    end

    // Present each returned bit half a cycle ahead of the master's sampling edge.
    always @(negedge clk) begin
        if (slv_rd_act && !ss_n && slv_cnt >= FW + RD_LAT && slv_cnt < FW + RD_LAT + MW)
            miso = slv_tx[FW + RD_LAT + MW - 1 - slv_cnt];
        else
            miso = 1'b0;
    end

    // ---------------- capture helpers ----------------
    logic       log_ss    [0:LOG_N-1];
    logic       log_mosi  [0:LOG_N-1];
    logic       log_rv    [0:LOG_N-1];
    logic       log_busy  [0:LOG_N-1];
    logic       log_ready [0:LOG_N-1];
    logic [7:0] log_rd    [0:LOG_N-1];

    task automatic record(input int t);
        log_ss[t]    = ss_n;
        log_mosi[t]  = mosi;
        log_rv[t]    = rd_valid;
        log_busy[t]  = busy;
        log_ready[t] = cmd_ready;
        log_rd[t]    = rd_data;
    endtask

    // Ends #1 after the accept edge (t = 0). ok = 0 if no acceptance within the budget.
    task automatic wait_accept(output bit ok);
        ok = 1'b0;
        for (int g = 0; g < 40; g++) begin
            @(negedge clk);
            if (cmd_ready && cmd_valid) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic capture(input int n);
        for (int t = 0; t < n; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            record(t);
        end
    endtask

    function automatic logic [9:0] mosi_seq(input int first);
        logic [9:0] s = '0;
        for (int i = 0; i < 10; i++) s = {s[8:0], log_mosi[first + i]};
        return s;
    endfunction

    function automatic int rise_at();
        for (int t = 1; t < LOG_N; t++)
            if (log_ss[t] === 1'b1 && log_ss[t-1] === 1'b0) return t;
        return -1;
    endfunction

    function automatic int low_count(input int n);
        int c = 0;
        for (int t = 0; t < n; t++) if (log_ss[t] === 1'b0) c++;
        return c;
    endfunction

    function automatic int rv_count(input int n);
        int c = 0;
        for (int t = 0; t < n; t++) if (log_rv[t] !== 1'b0) c++;
        return c;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst       = 1'b1;
        cmd_valid = 1'b1;
        cmd_type  = 2'b01;
        cmd_data  = 8'hFF;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({ss_n, mosi, rd_valid, busy} !== 4'b1000) begin
            n_bad++;
            $display("FAIL reset_pins: got ss/mosi/rv/busy=%b want 1000", {ss_n, mosi, rd_valid, busy});
        end
        n_cmp++;
        if (rd_data !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_rd_data: got %h want 00", rd_data);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ready_low: got %b want 0", cmd_ready);
        end
        rst       = 1'b0;
        cmd_valid = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_ready_after: got %b want 1", cmd_ready);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if ({ss_n, busy} !== 2'b10) begin
            n_bad++;
            $display("FAIL reset_idle: got ss/busy=%b want 10", {ss_n, busy});
        end
    endtask

    task automatic test_write_addr();
        bit ok;
        cmd_type  = 2'b00;
        cmd_data  = 8'hA5;
        cmd_valid = 1'b1;
        wait_accept(ok);
        cmd_valid = 1'b0;
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL wa_accept: got no acceptance want accepted");
        end
        capture(30);
        // SS_n goes low on edge 1 and rises on edge 12 after acceptance.
        n_cmp++;
        if (rise_at() !== 12 || low_count(30) !== 11) begin
            n_bad++;
            $display("FAIL wa_ss_n: got rise=%0d low=%0d want rise=12 low=11", rise_at(), low_count(30));
        end
        n_cmp++;
        if (mosi_seq(2) !== 10'b00_1010_0101) begin
            n_bad++;
            $display("FAIL wa_mosi: got %b want 0010100101", mosi_seq(2));
        end
        n_cmp++;
        if ({log_mosi[1], log_mosi[12]} !== 2'b00) begin
            n_bad++;
            $display("FAIL wa_mosi_idle: got %b want 00", {log_mosi[1], log_mosi[12]});
        end
        n_cmp++;
        if (rv_count(30) !== 0) begin
            n_bad++;
            $display("FAIL wa_no_rv: got %0d pulses want 0", rv_count(30));
        end
        n_cmp++;
        if ({log_busy[0], log_busy[11], log_busy[12], log_ready[12]} !== 4'b1101) begin
            n_bad++;
            $display("FAIL wa_busy: got %b want 1101", {log_busy[0], log_busy[11], log_busy[12], log_ready[12]});
        end
    endtask

    task automatic test_read_data();
        bit ok;
        // The slave's rd_addr is 0 after reset and mem[0] = C3, so MISO
        // carries 1,1,0,0,0,0,1,1.
        cmd_type  = 2'b11;
        cmd_data  = 8'h00;
        cmd_valid = 1'b1;
        wait_accept(ok);
        cmd_valid = 1'b0;
        n_cmp++;
        if (ok !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_accept: got no acceptance want accepted");
        end
        capture(30);
        n_cmp++;
        if (rise_at() !== 22 || low_count(30) !== 21) begin
            n_bad++;
            $display("FAIL rd_ss_n: got rise=%0d low=%0d want rise=22 low=21", rise_at(), low_count(30));
        end
        n_cmp++;
        if (mosi_seq(2) !== 10'b11_0000_0000) begin
            n_bad++;
            $display("FAIL rd_mosi: got %b want 1100000000", mosi_seq(2));
        end
        n_cmp++;
        if (rv_count(30) !== 1 || log_rv[22] !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_valid: got count=%0d at22=%b want count=1 at22=1", rv_count(30), log_rv[22]);
        end
        n_cmp++;
        if (log_rd[21] !== 8'h00 || log_rd[22] !== 8'hC3) begin
            n_bad++;
            $display("FAIL rd_data: got t21=%h t22=%h want t21=00 t22=c3", log_rd[21], log_rd[22]);
        end
        n_cmp++;
        if ({log_busy[21], log_busy[22]} !== 2'b10) begin
            n_bad++;
            $display("FAIL rd_busy: got %b want 10", {log_busy[21], log_busy[22]});
        end
    endtask

    task automatic test_reset_midframe();
        bit ok;
        int rv_seen;
        int low_seen;
        cmd_type  = 2'b11;
        cmd_data  = 8'h5A;
        cmd_valid = 1'b1;
        wait_accept(ok);
        cmd_valid = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        // t = 7: MOSI shows bit 5 of frame 11_0101_1010, which is 1.
        n_cmp++;
        if (ok !== 1'b1 || ss_n !== 1'b0 || mosi !== 1'b1) begin
            n_bad++;
            $display("FAIL mr_in_frame: got ok/ss/mosi=%b%b%b want 101", ok, ss_n, mosi);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({ss_n, mosi, rd_valid, busy, cmd_ready} !== 5'b10000) begin
            n_bad++;
            $display("FAIL mr_pins: got ss/mosi/rv/busy/ready=%b want 10000", {ss_n, mosi, rd_valid, busy, cmd_ready});
        end
        n_cmp++;
        if (rd_data !== 8'h00) begin
            n_bad++;
            $display("FAIL mr_rd_data: got %h want 00", rd_data);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL mr_idle: got ready=%b want 1", cmd_ready);
        end
        rv_seen  = 0;
        low_seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (rd_valid !== 1'b0) rv_seen++;
            if (ss_n !== 1'b1) low_seen++;
        end
        n_cmp++;
        if (rv_seen !== 0 || low_seen !== 0) begin
            n_bad++;
            $display("FAIL mr_abandoned: got rv=%0d ss_low=%0d want 0 0", rv_seen, low_seen);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        logic [39:0] ss_vec;
        int ready_early;
        cmd_type  = 2'b01;
        cmd_data  = 8'h3C;
        cmd_valid = 1'b1;
        wait_accept(ok);
        // Keep cmd_valid high with the next command so that it is offered
        // while the master is busy.
        cmd_type = 2'b10;
        cmd_data = 8'h07;
        for (int t = 0; t < LOG_N; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            record(t);
            if (t == 13) cmd_valid = 1'b0;
        end
        ready_early = 0;
        for (int t = 0; t < 12; t++) if (log_ready[t] !== 1'b0) ready_early++;
        for (int t = 0; t < LOG_N; t++) ss_vec[t] = log_ss[t];
        n_cmp++;
        if (ok !== 1'b1 || ready_early !== 0 || log_ready[12] !== 1'b1) begin
            n_bad++;
            $display("FAIL b2b_ready: got ok=%b early=%0d t12=%b want 1 0 1", ok, ready_early, log_ready[12]);
        end
        // Expected SS_n by edge:
        //   first frame low 1..11, high 12..13,
        //   second frame (accepted at edge 13) low 14..24, high from 25 on.
        n_cmp++;
        if (ss_vec !== 40'hFF_FE00_3001) begin
            n_bad++;
            $display("FAIL b2b_ss_n: got %h want fffe003001", ss_vec);
        end
        n_cmp++;
        if (mosi_seq(2) !== 10'b01_0011_1100) begin
            n_bad++;
            $display("FAIL b2b_mosi1: got %b want 0100111100", mosi_seq(2));
        end
        n_cmp++;
        if (mosi_seq(15) !== 10'b10_0000_0111) begin
            n_bad++;
            $display("FAIL b2b_mosi2: got %b want 1000000111", mosi_seq(15));
        end
        n_cmp++;
        if ({log_busy[12], log_busy[13], log_busy[25]} !== 3'b010 || rv_count(LOG_N) !== 0) begin
            n_bad++;
            $display("FAIL b2b_busy: got busy12/13/25=%b rv=%0d want 010 0",
                     {log_busy[12], log_busy[13], log_busy[25]}, rv_count(LOG_N));
        end
    endtask

    task automatic send_and_wait(input logic [1:0] ty, input logic [7:0] d,
                                 output bit ok, output int rv_cnt, output logic [7:0] last_rd);
        bit acc;
        rv_cnt    = 0;
        last_rd   = rd_data;
        cmd_type  = ty;
        cmd_data  = d;
        cmd_valid = 1'b1;
        wait_accept(acc);
        cmd_valid = 1'b0;
        ok = 1'b0;
        if (acc) begin
            for (int g = 0; g < 40; g++) begin
                @(posedge clk);
                #1;
                if (rd_valid === 1'b1) begin
                    rv_cnt++;
                    last_rd = rd_data;
                end
                if (busy === 1'b0) begin
                    ok = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic test_full_loop();
        bit ok_a, ok_b, ok_c, ok_d;
        int rv_a, rv_b, rv_c, rv_d;
        logic [7:0] rd_a, rd_b, rd_c, rd_d;
        send_and_wait(2'b00, 8'h10, ok_a, rv_a, rd_a);
        send_and_wait(2'b01, 8'h5A, ok_b, rv_b, rd_b);
        send_and_wait(2'b10, 8'h10, ok_c, rv_c, rd_c);
        send_and_wait(2'b11, 8'h00, ok_d, rv_d, rd_d);
        n_cmp++;
        if ({ok_a, ok_b, ok_c, ok_d} !== 4'b1111) begin
            n_bad++;
            $display("FAIL loop_complete: got %b want 1111", {ok_a, ok_b, ok_c, ok_d});
        end
        n_cmp++;
        if (rv_a + rv_b + rv_c !== 0 || rv_d !== 1) begin
            n_bad++;
            $display("FAIL loop_rv: got writes=%0d read=%0d want 0 1", rv_a + rv_b + rv_c, rv_d);
        end
        n_cmp++;
        if (rd_d !== 8'h5A || rd_data !== 8'h5A) begin
            n_bad++;
            $display("FAIL loop_rd_data: got pulse=%h held=%h want 5a 5a", rd_d, rd_data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_write_addr();
        test_read_data();
        test_reset_midframe();
        test_back_to_back();
        test_full_loop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
